full_adder: RTL and testbench

//   Registered full adder: adds operands a and b plus a 1-bit carry-in c, and

---
 rtl/full_adder_pkg.sv | 21 ++
 rtl/full_adder_cell.sv | 19 +
 rtl/full_adder.sv | 79 +++++++
 tb/tb_full_adder.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// rtl/full_adder_pkg.sv - shared constants and golden model for the registered full adder
//
// Purpose : width limits for full_adder and the fa_ref reference function.
// Contents: FA_DEFAULT_WIDTH, FA_MAX_WIDTH, fa_ref(a, b, c).
package full_adder_pkg;

   localparam int FA_DEFAULT_WIDTH = 1;
   localparam int FA_MAX_WIDTH     = 64;

   // Golden model: full-precision a + b + c.
   // Bit FA_MAX_WIDTH holds the carry when the operands are FA_MAX_WIDTH wide.
   // Narrower operands are zero-extended by the caller.
   function automatic logic [FA_MAX_WIDTH:0] fa_ref(
      input logic [FA_MAX_WIDTH-1:0] a,
      input logic [FA_MAX_WIDTH-1:0] b,
      input logic                    c
   );
      return {1'b0, a} + {1'b0, b} + {{FA_MAX_WIDTH{1'b0}}, c};
   endfunction

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - combinational 1-bit full adder cell
//
// Purpose : one ripple-chain leaf, s = a ^ b ^ cin, cout = majority(a, b, cin).
// Ports   : a, b, cin  in  1-bit operands and carry-in
//           s, cout    out sum bit and carry-out
module full_adder_cell
   import full_adder_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - registered ripple-carry adder, {carry, sum} = a + b + c
//
// Purpose : WIDTH chained full_adder_cell instances feeding one register stage.
// Ports   : clk, rst_n      clock, synchronous active-low reset
//           in_valid        qualifies a, b, c this cycle
//           a, b            WIDTH-bit unsigned operands
//           c               carry-in
//           sum, carry      registered result (carry is bit WIDTH of a+b+c)
//           out_valid       sum/carry hold a new result this cycle
module full_adder
   import full_adder_pkg::*;
#(
   parameter int WIDTH = FA_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             out_valid
);

   if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
      $fatal(1, "full_adder: WIDTH %0d outside 1..%0d", WIDTH, FA_MAX_WIDTH);
   end

   // chain[i] is the carry into bit i; chain[WIDTH] is the final carry-out.
   logic [WIDTH:0]   chain;
   logic [WIDTH-1:0] sum_comb;

   assign chain[0] = c;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      full_adder_cell u_cell (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (chain[i]),
         .s    (sum_comb[i]),
         .cout (chain[i+1])
      );
   end

   logic [WIDTH-1:0] sum_d,   sum_q;
   logic             carry_d, carry_q;
   logic             valid_d, valid_q;

   // The result registers only load when in_valid is high, so whatever sits
   // on a/b/c while idle cannot disturb the held result.
   always_comb begin
      sum_d   = sum_q;
      carry_d = carry_q;
      valid_d = 1'b0;
      if (in_valid) begin
         sum_d   = sum_comb;
         carry_d = chain[WIDTH];
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_q   <= '0;
         carry_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         sum_q   <= sum_d;
         carry_q <= carry_d;
         valid_q <= valid_d;
      end
   end

   assign sum       = sum_q;
   assign carry     = carry_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - scoreboard bench for full_adder at WIDTH=1 and WIDTH=8
module tb_full_adder;

   logic       clk = 1'b0;
   logic       rst_n;

   logic       v1, a1, b1, c1;
   logic       s1, co1, ov1;

   logic       v8, c8;
   logic [7:0] a8, b8;
   logic [7:0] s8;
   logic       co8, ov8;

   int n_cmp = 0;
   int n_bad = 0;
   int n_valid8 = 0;

   logic [1:0] exp_q1[$];
   logic [8:0] exp_q8[$];

   always #5 clk = ~clk;

   full_adder #(.WIDTH(1)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (v1),
      .a         (a1),
      .b         (b1),
      .c         (c1),
      .sum       (s1),
      .carry     (co1),
      .out_valid (ov1)
   );

   full_adder #(.WIDTH(8)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (v8),
      .a         (a8),
      .b         (b8),
      .c         (c8),
      .sum       (s8),
      .carry     (co8),
      .out_valid (ov8)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain integer addition at full precision.
   task automatic issue1(input logic a, input logic b, input logic c);
      a1 = a; b1 = b; c1 = c; v1 = 1'b1;
      exp_q1.push_back(2'(int'(a) + int'(b) + int'(c)));
   endtask

   task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
      a8 = a; b8 = b; c8 = c; v8 = 1'b1;
      exp_q8.push_back(9'(int'(a) + int'(b) + int'(c)));
   endtask

   // Monitors: pop and compare whenever a DUT presents a result.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (ov1 === 1'b1) begin
            if (exp_q1.size() == 0) check("w1_unexpected_valid", 64'(ov1), 64'd0);
            else check("w1_result", 64'({co1, s1}), 64'(exp_q1.pop_front()));
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         if (ov8 === 1'b1) begin
            n_valid8++;
            if (exp_q8.size() == 0) check("w8_unexpected_valid", 64'(ov8), 64'd0);
            else check("w8_result", 64'({co8, s8}), 64'(exp_q8.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset held for two edges while valid all-ones input is offered.
      rst_n = 1'b0;
      v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
      v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_sum1",   64'(s1),  64'd0);
      check("rst_carry1", 64'(co1), 64'd0);
      check("rst_valid1", 64'(ov1), 64'd0);
      check("rst_sum8",   64'(s8),  64'd0);
      check("rst_valid8", 64'(ov8), 64'd0);

      // Release: the still-present 1,1,1 gives sum=1 carry=1 one edge later.
      rst_n = 1'b1;
      issue1(1'b1, 1'b1, 1'b1);
      v8 = 1'b0;
      @(negedge clk);
      check("post_rst_sum1",   64'(s1),  64'd1);
      check("post_rst_carry1", 64'(co1), 64'd1);

      // Exhaustive 1-bit truth table, one vector per cycle.
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         issue1(v[2], v[1], v[0]);
         @(negedge clk);
      end

      // Hold: register s=1 c=0, then idle with all-ones on the inputs.
      issue1(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      v1 = 1'b0; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_sum",   64'(s1),  64'd1);
         check("hold_carry", 64'(co1), 64'd0);
         check("hold_valid", 64'(ov1), 64'd0);
      end

      // 8-bit wrap boundaries.
      issue8(8'hFF, 8'h00, 1'b1);
      @(negedge clk);
      check("wrap_ff_sum",   64'(s8),  64'h00);
      check("wrap_ff_carry", 64'(co8), 64'd1);
      issue8(8'h80, 8'h80, 1'b0);
      @(negedge clk);
      check("wrap_80_sum",   64'(s8),  64'h00);
      check("wrap_80_carry", 64'(co8), 64'd1);

      // Back-to-back random burst.
      for (int i = 0; i < 100; i++) begin
         issue8(8'($urandom), 8'($urandom), 1'($urandom));
         @(negedge clk);
         check("b2b_valid", 64'(ov8), 64'd1);
      end
      v8 = 1'b0;
      repeat (3) @(negedge clk);
      check("w8_idle_valid", 64'(ov8), 64'd0);

      check("w1_queue_drained", 64'(exp_q1.size()), 64'd0);
      check("w8_queue_drained", 64'(exp_q8.size()), 64'd0);
      check("w8_valid_count",   64'(n_valid8),      64'd102);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
